disk_xfer_ctrl: RTL and testbench
=================================

DISK_XFER_CTRL -- requirements
Module: disk_xfer_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width of disk and main memory.
REQ-002 SHALL have parameter DISK_ADDR_WIDTH, default 15, disk word address width.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 10, main-memory word address width.
REQ-004 SHALL have parameter LEN_WIDTH, default 8, transfer length width in words.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  command request, sampled in IDLE only.
REQ-008 SHALL have port dir  input  1  0 = disk to memory (load), 1 = memory to disk (store).
REQ-009 SHALL have ports disk_base (input, DISK_ADDR_WIDTH), mem_base (input, MEM_ADDR_WIDTH), len (input, LEN_WIDTH): first disk word, first memory word, word count.
REQ-010 SHALL have ports disk_addr (output, DISK_ADDR_WIDTH), disk_data (output, DATA_WIDTH), disk_tr (output, 1), disk_q (input, DATA_WIDTH): disk side, synchronous write on disk_tr, combinational read q.
REQ-011 SHALL have ports mem_addr (output, MEM_ADDR_WIDTH), mem_data (output, DATA_WIDTH), mem_we (output, 1), mem_q (input, DATA_WIDTH): memory side, same timing as disk.
REQ-012 SHALL have ports busy, done, err  output  1 each: transfer in progress, one-cycle completion pulse, one-cycle rejection pulse.

Function
REQ-013 SHALL implement states IDLE, XFER, DONE; IDLE->XFER on start with len>0; IDLE->DONE on start with len=0; XFER->DONE after last word; DONE->IDLE unconditionally.
REQ-014 SHALL latch dir, disk_base, mem_base, len on the accepting edge; later input changes SHALL not affect the transfer.
REQ-015 SHALL ignore start while busy (no queuing, no error).
REQ-016 SHALL move exactly one word per XFER cycle: source q passed combinationally to destination data, destination write strobe high that cycle.
REQ-017 SHALL drive disk_addr/mem_addr from registered counters, incrementing by 1 after each word.
REQ-018 SHALL never assert the write strobe of the source side; both strobes low outside XFER.
REQ-019 SHALL, for command accepted at edge 0 with len=N>0, write words in cycles 1..N, pulse done in cycle N+1, hold busy in cycles 1..N+1.
REQ-020 SHALL, for len=0, perform no writes and pulse done in cycle 1.
REQ-021 SHALL wrap address counters modulo 2**width when the macro of REQ-026 is undefined.
REQ-022 SHALL hold disk_data/mem_data at zero when not in XFER.

Reset
REQ-023 SHALL, on rst, enter IDLE immediately with busy, done, err, disk_tr, mem_we, all addresses and counters at 0.
REQ-024 SHALL, on rst mid-transfer, abort with no further writes and no done pulse; words already written remain.
REQ-025 SHALL accept a new start on the first edge after rst deasserts.

Configuration
REQ-026 SHALL, with DISK_XFER_BOUNDS_EN defined, reject any command where base+len exceeds 2**DISK_ADDR_WIDTH or 2**MEM_ADDR_WIDTH: no writes, err pulse in cycle 1, no done; without it err SHALL be tied 0 and addresses wrap (REQ-021).

Structure
REQ-027 SHALL place state enum and DIR_LOAD/DIR_STORE constants in shared package disk_xfer_pkg.
REQ-028 SHALL use one sub-module, xfer_addr_cnt (loadable incrementing counter), instantiated twice (disk, memory) plus once for remaining length.

Verification
REQ-029 Load: disk[100..103]=A1,A2,A3,A4, start dir=0 disk_base=100 mem_base=8 len=4 -> mem[8..11]=A1..A4, done in cycle 5, disk_tr never high.
REQ-030 Store: mem[0..1]=0x1234,0x5678, dir=1 mem_base=0 disk_base=200 len=2 -> disk[200..201] updated, done in cycle 3, mem_we never high.
REQ-031 len=0 -> done in cycle 1, no strobes, busy only cycle 1.
REQ-032 start re-pulsed during busy with other base -> ignored, original transfer completes unchanged.
REQ-033 rst asserted in cycle 2 of len=4 load -> only first word written, outputs zero immediately, no done.
REQ-034 disk_base=0x7FFE len=4: without macro -> disk addresses 7FFE,7FFF,0000,0001; with DISK_XFER_BOUNDS_EN -> err in cycle 1, no writes.

Source files
------------

// File: rtl/disk_xfer_pkg.sv
// disk_xfer_pkg: shared FSM state and transfer-direction constants for the disk transfer controller.
package disk_xfer_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  localparam logic DIR_LOAD = 1'b0;
  localparam logic DIR_STORE = 1'b1;
endpackage

// File: rtl/xfer_addr_cnt.sv
// xfer_addr_cnt: loadable incrementing counter used for both address streams and the remaining-length count.
module xfer_addr_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (inc_i) cnt_q <= cnt_q + W'(1);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/disk_xfer_ctrl.sv
// disk_xfer_ctrl: one-word-per-cycle block copy between disk and main memory.
// Define DISK_XFER_BOUNDS_EN to reject out-of-range commands with err instead of wrapping addresses.
module disk_xfer_ctrl import disk_xfer_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int DISK_ADDR_WIDTH = 15,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       dir,
  input  logic [DISK_ADDR_WIDTH-1:0] disk_base,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_base,
  input  logic [LEN_WIDTH-1:0]       len,
  output logic [DISK_ADDR_WIDTH-1:0] disk_addr,
  output logic [DATA_WIDTH-1:0]      disk_data,
  output logic                       disk_tr,
  input  logic [DATA_WIDTH-1:0]      disk_q,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_data,
  output logic                       mem_we,
  input  logic [DATA_WIDTH-1:0]      mem_q,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  state_t state_q;
  logic dir_q, busy_q, done_q, err_q;
  logic accept, xfer, last, oob;
  logic [LEN_WIDTH-1:0] rem;
  assign accept = state_q == IDLE && start;
  assign xfer = state_q == XFER;
  // rem counts up from -len, so all-ones marks the final word
  assign last = &rem;
`ifdef DISK_XFER_BOUNDS_EN
  logic [32:0] disk_end, mem_end;
  assign disk_end = 33'(disk_base) + 33'(len);
  assign mem_end = 33'(mem_base) + 33'(len);
  assign oob = disk_end > (33'(1) << DISK_ADDR_WIDTH) || mem_end > (33'(1) << MEM_ADDR_WIDTH);
`else
  assign oob = 1'b0;
`endif
  xfer_addr_cnt #(.W(DISK_ADDR_WIDTH)) u_disk_cnt (
    .clk(clk), .rst(rst), .load_i(accept), .inc_i(xfer), .val_i(disk_base), .cnt_o(disk_addr)
  );
  xfer_addr_cnt #(.W(MEM_ADDR_WIDTH)) u_mem_cnt (
    .clk(clk), .rst(rst), .load_i(accept), .inc_i(xfer), .val_i(mem_base), .cnt_o(mem_addr)
  );
  xfer_addr_cnt #(.W(LEN_WIDTH)) u_rem_cnt (
    .clk(clk), .rst(rst), .load_i(accept), .inc_i(xfer), .val_i(-len), .cnt_o(rem)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      dir_q <= DIR_LOAD;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          dir_q <= dir;
          busy_q <= 1'b1;
          err_q <= oob;
          done_q <= len == '0 && !oob;
          state_q <= (len == '0 || oob) ? DONE : XFER;
        end
        XFER: if (last) begin
          done_q <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          err_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  assign mem_we = xfer && dir_q == DIR_LOAD;
  assign disk_tr = xfer && dir_q == DIR_STORE;
  assign mem_data = mem_we ? disk_q : '0;
  assign disk_data = disk_tr ? mem_q : '0;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_disk_xfer_ctrl.sv
// tb_disk_xfer_ctrl: table-driven and randomized checks of disk_xfer_ctrl against array-copy reference images.
module tb_disk_xfer_ctrl;
  localparam int DW = 16, AW = 15, MW = 10, LW = 8;
  localparam int DSZ = 1 << AW, MSZ = 1 << MW;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, dir = 1'b0;
  logic [AW-1:0] disk_base = '0, disk_addr;
  logic [MW-1:0] mem_base = '0, mem_addr;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] disk_data, disk_q, mem_data, mem_q;
  logic disk_tr, mem_we, busy, done, err;
  logic [DW-1:0] disk_m [DSZ];
  logic [DW-1:0] mem_m [MSZ];
  logic [DW-1:0] ref_disk [DSZ];
  logic [DW-1:0] ref_mem [MSZ];
  logic filled = 1'b0;
  int n_cmp = 0, n_bad = 0;

  disk_xfer_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .disk_base(disk_base), .mem_base(mem_base),
    .len(len), .disk_addr(disk_addr), .disk_data(disk_data), .disk_tr(disk_tr), .disk_q(disk_q),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] disk_init(int i);
    if (i >= 100 && i <= 103) return DW'(16'h00A1 + i - 100);
    return DW'(i * 40503 + 16'h5A5A);
  endfunction

  function automatic logic [DW-1:0] mem_init(int i);
    if (i == 0) return 16'h1234;
    if (i == 1) return 16'h5678;
    return DW'(i * 7919 + 16'hC3C3);
  endfunction

  assign disk_q = disk_m[disk_addr];
  assign mem_q = mem_m[mem_addr];
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < DSZ; i++) disk_m[i] <= disk_init(i);
      for (int i = 0; i < MSZ; i++) mem_m[i] <= mem_init(i);
      filled <= 1'b1;
    end
    if (disk_tr) disk_m[disk_addr] <= disk_data;
    if (mem_we) mem_m[mem_addr] <= mem_data;
  end

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int image_diff();
    int d = 0;
    for (int i = 0; i < DSZ; i++) if (disk_m[i] !== ref_disk[i]) d++;
    for (int i = 0; i < MSZ; i++) if (mem_m[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  task automatic run_cmd(string tag, bit d, int db, int mb, int n, bit rep, int exp_done, int exp_wr);
    int done_cyc = 0, done_cnt = 0, err_cyc = 0, err_cnt = 0, wr = 0, src = 0;
    int busy_cnt = 0, addr_bad = 0, data_bad = 0;
    bit oob = 1'b0;
    bit ds;
`ifdef DISK_XFER_BOUNDS_EN
    oob = db + n > DSZ || mb + n > MSZ;
`endif
    if (oob) begin
      exp_done = 0;
      exp_wr = 0;
    end else
      for (int i = 0; i < n; i++)
        if (d) ref_disk[(db + i) % DSZ] = ref_mem[(mb + i) % MSZ];
        else ref_mem[(mb + i) % MSZ] = ref_disk[(db + i) % DSZ];
    dir = d;
    disk_base = AW'(db);
    mem_base = MW'(mb);
    len = LW'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dir = ~d;
    disk_base = AW'($urandom);
    mem_base = MW'($urandom);
    len = LW'($urandom);
    for (int c = 1; c <= n + 3; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (err) begin
        err_cnt++;
        if (err_cyc == 0) err_cyc = c;
      end
      busy_cnt += int'(busy);
      src += int'(d ? mem_we : disk_tr);
      ds = d ? disk_tr : mem_we;
      if (ds) begin
        wr++;
        if (int'(disk_addr) != (db + c - 1) % DSZ || int'(mem_addr) != (mb + c - 1) % MSZ) addr_bad++;
      end else if (disk_data != '0 || mem_data != '0) data_bad++;
      if (rep && c == 2) begin
        start = 1'b1;
        dir = ~d;
        disk_base = AW'(db + 7);
        mem_base = MW'(mb + 3);
      end else start = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, ":done_cycle"}, done_cyc, exp_done);
    check({tag, ":done_pulses"}, done_cnt, exp_done != 0 ? 1 : 0);
    check({tag, ":writes"}, wr, exp_wr);
    check({tag, ":src_strobe"}, src, 0);
    check({tag, ":addr_seq"}, addr_bad, 0);
    check({tag, ":idle_data"}, data_bad, 0);
    check({tag, ":err_cycle"}, err_cyc, oob ? 1 : 0);
    check({tag, ":err_pulses"}, err_cnt, oob ? 1 : 0);
    if (!oob) check({tag, ":busy_cycles"}, busy_cnt, n + 1);
    check({tag, ":image"}, image_diff(), 0);
  endtask

  typedef struct {
    bit d;
    int db;
    int mb;
    int n;
    bit rep;
    int exp_done;
    int exp_wr;
  } vec_t;

  vec_t vecs [8];
  int bad;

  initial begin
    vecs[0] = '{1'b0, 100, 8, 4, 1'b0, 5, 4};
    vecs[1] = '{1'b1, 200, 0, 2, 1'b0, 3, 2};
    vecs[2] = '{1'b0, 500, 20, 0, 1'b0, 1, 0};
    vecs[3] = '{1'b0, 1000, 100, 5, 1'b1, 6, 5};
    vecs[4] = '{1'b1, 3000, 512, 1, 1'b1, 2, 1};
    vecs[5] = '{1'b0, 32000, 700, 255, 1'b0, 256, 255};
    vecs[6] = '{1'b0, 32766, 8, 4, 1'b0, 5, 4};
    vecs[7] = '{1'b1, 32767, 1022, 3, 1'b0, 4, 3};
    for (int i = 0; i < DSZ; i++) ref_disk[i] = disk_init(i);
    for (int i = 0; i < MSZ; i++) ref_mem[i] = mem_init(i);
    #12;
    check("reset_strobes", int'({busy, done, err, disk_tr, mem_we}), 0);
    check("reset_addr", int'(disk_addr) + int'(mem_addr), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("preload", image_diff(), 0);
    for (int i = 0; i < 8; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].d, vecs[i].db, vecs[i].mb, vecs[i].n, vecs[i].rep,
              vecs[i].exp_done, vecs[i].exp_wr);
      if (i == 0) check("load_word3", int'(mem_m[11]), 16'h00A4);
      if (i == 1) check("store_word1", int'(disk_m[201]), 16'h5678);
    end
    // reset during the second cycle of a four-word load
    dir = 1'b0;
    disk_base = AW'(300);
    mem_base = MW'(50);
    len = LW'(4);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_ctrl", int'({busy, done, err, disk_tr, mem_we}), 0);
    check("rst_mid_bus", int'(disk_addr) + int'(mem_addr) + int'(disk_data) + int'(mem_data), 0);
    ref_mem[50] = ref_disk[300];
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done || disk_tr || mem_we || busy) bad++;
    end
    check("rst_quiet", bad, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_partial", image_diff(), 0);
    run_cmd("after_rst", 1'b1, 4000, 60, 3, 1'b0, 4, 3);
    for (int r = 0; r < 25; r++) begin
      int n, db, mb;
      bit d, rep;
      n = int'($urandom_range(40, 0));
      db = int'($urandom_range(DSZ - n, 0));
      mb = int'($urandom_range(MSZ - n, 0));
      d = 1'($urandom);
      rep = n >= 1 && 1'($urandom);
      run_cmd($sformatf("rnd%0d", r), d, db, mb, n, rep, n + 1, n);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
